// File: rtl/receiver.sv
// receiver: UART receiver (8N1, LSB first) oversampled on clk, with rdy/ack
// handoff and framing/overrun error pulses.
// Optional macro RECEIVER_PARITY_EN: 8E1 framing with a parity-error pulse on perr.
module receiver #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rcv,
    input  logic       ack,
    output logic [7:0] data,
    output logic       rdy,
    output logic       ferr,
    output logic       ovr,
    output logic       perr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef RECEIVER_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;
`endif

    state_t           state;
    state_t           state_d;
    logic             sync1;
    logic             rcv_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             bit_end;
    logic             idx_clr;
    logic             shift_en;
    logic             frame_ok;
    logic             frame_bad;
    logic             done_q;
    logic             bad_q;
`ifdef RECEIVER_PARITY_EN
    logic             par_en;
    logic             par_bit;
`endif

    assign bit_end = (cnt == LAST);

    // Two-flop synchroniser for the asynchronous serial line, idles high
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1 <= 1'b1;
            rcv_s <= 1'b1;
        end else begin
            sync1 <= rcv;
            rcv_s <= sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!clr) state <= ST_IDLE;
        else      state <= state_d;
    end

    // Next-state logic: start qualification, bit stepping, stop check, break wait
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:   if (!rcv_s) state_d = ST_START;
            ST_START:  if (cnt == HALF) state_d = rcv_s ? ST_IDLE : ST_DATA;
`ifdef RECEIVER_PARITY_EN
            ST_DATA:   if (bit_end && idx == 3'd7) state_d = ST_PARITY;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`else
            ST_DATA:   if (bit_end && idx == 3'd7) state_d = ST_STOP;
`endif
            ST_STOP:   if (bit_end) state_d = rcv_s ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rcv_s) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM control strobes and bit-counter next value
    always_comb begin
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
`ifdef RECEIVER_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            ST_START:  idx_clr = (cnt == HALF) && !rcv_s;
            ST_DATA:   shift_en = bit_end;
`ifdef RECEIVER_PARITY_EN
            ST_PARITY: par_en = bit_end;
`endif
            ST_STOP: begin
                frame_ok  = bit_end && rcv_s;
                frame_bad = bit_end && !rcv_s;
            end
            default: ;
        endcase
        if (state_d != state || bit_end || state == ST_IDLE || state == ST_BREAK)
            cnt_d = '0;
        else
            cnt_d = cnt + CNT_W'(1);
    end

    // Datapath: sampling, stop-result pipeline stage, delivery and error pulses.
    // The stop result is registered once so outputs move the cycle after the stop sample.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            done_q <= 1'b0;
            bad_q  <= 1'b0;
            data   <= '0;
            rdy    <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
`ifdef RECEIVER_PARITY_EN
            par_bit <= 1'b0;
            perr    <= 1'b0;
`endif
        end else begin
            cnt <= cnt_d;
            if (idx_clr)       idx <= '0;
            else if (shift_en) idx <= idx + 3'd1;
            if (shift_en) shreg[idx] <= rcv_s;
`ifdef RECEIVER_PARITY_EN
            if (par_en) par_bit <= rcv_s;
            perr <= 1'b0;
`endif
            done_q <= frame_ok;
            bad_q  <= frame_bad;
            ferr   <= bad_q;
            ovr    <= 1'b0;
            if (done_q) begin
                if (!rdy || ack) begin
                    data <= shreg;
                    rdy  <= 1'b1;
`ifdef RECEIVER_PARITY_EN
                    perr <= ^{shreg, par_bit};
`endif
                end else begin
                    ovr <= 1'b1;
                end
            end else if (ack) begin
                rdy <= 1'b0;
            end
        end
    end

`ifndef RECEIVER_PARITY_EN
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_receiver.sv
// Directed testbench for receiver: reset, back-to-back frames, glitch rejection,
// framing error with held-low line, overrun, coincident ack, and optional parity.
module tb_receiver;

    localparam int unsigned CPB = 16;
`ifdef RECEIVER_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    // Cycles from the rcv falling edge (driven just after edge E0) to rdy visible:
    // t0 = E0+3 (synchroniser), outputs move at t0+CPB/2+(FRAME_BITS-1)*CPB+1.
    localparam int unsigned RDY_AT = FRAME_BITS * CPB - 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       rcv;
    logic       ack;
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       ovr;
    logic       perr;

    int tests = 0;
    int fails = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    int f0;
    int o0;
    int p0;

    receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .clr  (clr),
        .rcv  (rcv),
        .ack  (ack),
        .data (data),
        .rdy  (rdy),
        .ferr (ferr),
        .ovr  (ovr),
        .perr (perr)
    );

    always #5 clk = ~clk;

    // Count single-cycle pulses away from the active edge
    always @(negedge clk) begin
        if (ferr === 1'b1) ferr_cnt++;
        if (ovr === 1'b1)  ovr_cnt++;
        if (perr === 1'b1) perr_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting just after a rising edge; line is left at stop_bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        rcv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rcv = b[i];
            tick(CPB);
        end
`ifdef RECEIVER_PARITY_EN
        rcv = (^b) ^ bad_par;
        tick(CPB);
`else
        if (bad_par) $display("note: parity flip ignored in 8N1 build");
`endif
        rcv = stop_bit;
        tick(CPB);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        clr = 1'b0;
        rcv = 1'b0;
        ack = 1'b0;
        @(posedge clk);
        #1;
        // Reset with a toggling line
        for (int i = 0; i < 5; i++) begin
            rcv = ~rcv;
            tick(1);
        end
        check("rst_data", data, 8'h00);
        check("rst_rdy", rdy, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_perr", perr, 1'b0);
        clr = 1'b1;
        rcv = 1'b1;
        tick(200);
        check("idle_rdy", rdy, 1'b0);
        check("idle_ferr_cnt", ferr_cnt, 0);

        // 0xAA then 0x55 back-to-back, exact delivery latency on the first
        fork
            begin
                send_frame(8'hAA, 1'b1, 1'b0);
                send_frame(8'h55, 1'b1, 1'b0);
            end
            begin
                tick(RDY_AT - 1);
                check("aa_rdy_early", rdy, 1'b0);
                tick(1);
                check("aa_rdy", rdy, 1'b1);
                check("aa_data", data, 8'hAA);
                do_ack();
                check("aa_ack_clear", rdy, 1'b0);
            end
        join
        check("b55_rdy", rdy, 1'b1);
        check("b55_data", data, 8'h55);
        check("b2b_ferr_cnt", ferr_cnt, 0);
        check("b2b_ovr_cnt", ovr_cnt, 0);
        do_ack();
        check("b55_ack_clear", rdy, 1'b0);

        // Glitch shorter than half a bit is rejected
        rcv = 1'b0;
        tick(4);
        rcv = 1'b1;
        tick(40);
        check("glitch_rdy", rdy, 1'b0);
        check("glitch_ferr_cnt", ferr_cnt, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("g3c_rdy", rdy, 1'b1);
        check("g3c_data", data, 8'h3C);
        do_ack();

        // Framing error followed by a long held-low line
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, 1'b0);
        tick(100);
        rcv = 1'b1;
        tick(20);
        check("ferr_once", ferr_cnt - f0, 1);
        check("ferr_rdy", rdy, 1'b0);
        check("ferr_data_kept", data, 8'h3C);
        send_frame(8'h42, 1'b1, 1'b0);
        check("f42_rdy", rdy, 1'b1);
        check("f42_data", data, 8'h42);
        do_ack();

        // Overrun: second byte dropped while first still pending
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        check("o11_data", data, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_once", ovr_cnt - o0, 1);
        check("ovr_data_kept", data, 8'h11);
        check("ovr_rdy", rdy, 1'b1);

        // Ack coincident with the delivery cycle: new byte accepted, no overrun
        fork
            send_frame(8'h33, 1'b1, 1'b0);
            begin
                tick(RDY_AT - 1);
                ack = 1'b1;
                tick(1);
                ack = 1'b0;
                check("coack_data", data, 8'h33);
                check("coack_rdy", rdy, 1'b1);
            end
        join
        check("coack_ovr_cnt", ovr_cnt - o0, 1);
        do_ack();

`ifdef RECEIVER_PARITY_EN
        // Even parity: correct bit, then flipped bit
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_ok_perr_cnt", perr_cnt - p0, 0);
        check("par_ok_data", data, 8'h07);
        do_ack();
        fork
            send_frame(8'h07, 1'b1, 1'b1);
            begin
                tick(RDY_AT);
                check("par_bad_perr", perr, 1'b1);
                check("par_bad_rdy", rdy, 1'b1);
                check("par_bad_data", data, 8'h07);
            end
        join
        check("par_bad_perr_cnt", perr_cnt - p0, 1);
        do_ack();
`else
        p0 = 0;
        check("noparity_perr_cnt", perr_cnt - p0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
